// File: rtl/rs_correct_apply.sv
// rs_correct_apply: applies an RS decoder error pattern to a captured codeword
// and streams the corrected bytes out over a valid/ready handshake.
// Optional feature macro: RS_CORRECT_ERRCNT_EN (compiles in the err_count counter).
module rs_correct_apply #(
  parameter int unsigned N_BYTES = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clrn,
  input  logic                 start,
  input  logic [N_BYTES*8-1:0] codeword,
  input  logic [N_BYTES*8-1:0] error_pos,
  input  logic                 with_error,
  output logic                 ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 done,
  output logic [7:0]           err_count
);

  localparam int unsigned W        = N_BYTES * 8;
  localparam logic [7:0]  LAST_IDX = 8'(N_BYTES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] cw_q, cw_d;
  logic [W-1:0] ep_q, ep_d;
  logic [7:0]   idx_q, idx_d;
  logic [7:0]   out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         done_q, done_d;
  logic         ready_q, ready_d;
  logic         xfer;
  logic [7:0]   idx_nxt;

  // Byte mux; out-of-range indices return zero instead of reading past the vector.
  function automatic logic [7:0] byte_at(input logic [W-1:0] v, input logic [7:0] i);
    logic [7:0] r;
    r = 8'd0;
    for (int unsigned k = 0; k < N_BYTES; k++) begin
      if (i == 8'(k)) r = v[k*8 +: 8];
    end
    return r;
  endfunction

  assign xfer    = out_valid_q & out_ready;
  assign idx_nxt = idx_q + 8'd1;

  // Next-state and output-register logic; synchronous clear overrides everything.
  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    ep_d        = ep_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    ready_d     = ready_q;
    if (!clrn) begin
      state_d     = S_IDLE;
      idx_d       = 8'd0;
      out_data_d  = 8'd0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      ready_d     = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cw_d    = codeword;
            ep_d    = with_error ? error_pos : '0;
            idx_d   = 8'd0;
            ready_d = 1'b0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          out_data_d  = byte_at(cw_q, 8'd0) ^ byte_at(ep_q, 8'd0);
          out_valid_d = 1'b1;
          out_last_d  = (LAST_IDX == 8'd0);
          state_d     = S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            if (out_last_q) begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              done_d      = 1'b1;
              state_d     = S_DONE;
            end else begin
              idx_d      = idx_nxt;
              out_data_d = byte_at(cw_q, idx_nxt) ^ byte_at(ep_q, idx_nxt);
              out_last_d = (idx_nxt == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cw_q        <= '0;
      ep_q        <= '0;
      idx_q       <= 8'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      ep_q        <= ep_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

`ifdef RS_CORRECT_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating count of nonzero error bytes actually handed downstream.
  always_comb begin
    err_count_d = err_count_q;
    if (!clrn || (state_q == S_IDLE && start)) begin
      err_count_d = 8'd0;
    end else if (state_q == S_STREAM && xfer && byte_at(ep_q, idx_q) != 8'd0 &&
                 err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count_q <= 8'd0;
    else        err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule
